// File: rtl/uart_pkg.sv
// Shared definitions for the command-frame UART link (TX and RX sides).
package uart_pkg;

  localparam logic [7:0] TOU_DEF       = 8'hdd;
  localparam logic [7:0] WEI_DEF       = 8'hee;
  localparam int         FRAME_BYTES   = 32;
  localparam int         PAYLOAD_BYTES = 30;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } bit_state_e;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_BUSY,
    FR_DONE
  } frame_state_e;

  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serialiser; start bit goes out on the edge that sees start.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 10
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);

  localparam int            CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  bit_state_e    state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (baud_cnt_q == BAUD_LAST);
  assign tx      = tx_q;

  // data must stay stable until byte_done; a start seen in the last stop cycle chains the next byte
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    byte_done  = 1'b0;
    if (state_q != BIT_IDLE) baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
    case (state_q)
      BIT_IDLE: begin
        if (start) begin
          state_d    = BIT_START;
          baud_cnt_d = '0;
          tx_d       = 1'b0;
        end
      end
      BIT_START: begin
        if (bit_end) begin
          state_d   = BIT_DATA;
          bit_cnt_d = '0;
          tx_d      = data[0];
        end
      end
      BIT_DATA: begin
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = BIT_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = data[bit_cnt_d];
          end
        end
      end
      BIT_STOP: begin
        if (bit_end) begin
          byte_done = 1'b1;
          if (start) begin
            state_d = BIT_START;
            tx_d    = 1'b0;
          end else begin
            state_d = BIT_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = BIT_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= BIT_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: rtl/uart_cmd_tx.sv
// Command-frame transmitter: frames a 240-bit payload as TOU + 30 bytes + WEI over 8N1.
module uart_cmd_tx
  import uart_pkg::*;
#(
  parameter logic [7:0] TOU       = TOU_DEF,
  parameter logic [7:0] WEI       = WEI_DEF,
  parameter int         CLK_FREQ  = 50_000_000,
  parameter int         BAUD      = 9600,
  parameter bit         MSB_FIRST = 1'b1
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         send_en,
  input  logic [239:0] payload,
  output logic         uart_tx,
  output logic         busy,
  output logic         tx_done
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);

  function automatic logic [239:0] byte_reverse(input logic [239:0] p);
    logic [239:0] r;
    r = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) r[8*i +: 8] = p[8*(PAYLOAD_BYTES-1-i) +: 8];
    return r;
  endfunction

  frame_state_e frame_state_q, frame_state_d;
  logic [255:0] shreg_q, shreg_d;
  logic [4:0]   byte_cnt_q, byte_cnt_d;
  logic         busy_q, busy_d;
  logic         tx_done_q, tx_done_d;
  logic         byte_start, byte_done;

  assign busy    = busy_q;
  assign tx_done = tx_done_q;

  // Next byte is requested combinationally so it follows the previous stop bit with no gap
  assign byte_start = ((frame_state_q == FR_IDLE) && send_en) ||
                      (byte_done && (byte_cnt_q != 5'd31));

  always_comb begin
    frame_state_d = frame_state_q;
    shreg_d       = shreg_q;
    byte_cnt_d    = byte_cnt_q;
    busy_d        = busy_q;
    tx_done_d     = 1'b0;
    case (frame_state_q)
      FR_IDLE: begin
        if (send_en) begin
          frame_state_d = FR_BUSY;
          busy_d        = 1'b1;
          byte_cnt_d    = '0;
          shreg_d       = {TOU, (MSB_FIRST ? payload : byte_reverse(payload)), WEI};
        end
      end
      FR_BUSY: begin
        if (byte_done) begin
          shreg_d    = {shreg_q[247:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 5'd31) begin
            frame_state_d = FR_DONE;
            busy_d        = 1'b0;
            tx_done_d     = 1'b1;
          end
        end
      end
      FR_DONE: frame_state_d = FR_IDLE;
      default: frame_state_d = FR_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      frame_state_q <= FR_IDLE;
      byte_cnt_q    <= '0;
      busy_q        <= 1'b0;
      tx_done_q     <= 1'b0;
    end else begin
      frame_state_q <= frame_state_d;
      byte_cnt_q    <= byte_cnt_d;
      busy_q        <= busy_d;
      tx_done_q     <= tx_done_d;
    end
  end

  always_ff @(posedge Clk) begin
    shreg_q <= shreg_d;
  end

  uart_byte_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_byte_tx (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .start    (byte_start),
    .data     (shreg_q[255:248]),
    .tx       (uart_tx),
    .byte_done(byte_done)
  );

endmodule
